// File: rtl/ap_pkg.sv
// Shared definitions for the Ascon permutation CSR host master.
// Holds the fixed CSR word map, state geometry, FSM encoding and the
// helper that locates a CSR word inside the packed 320-bit state.
package ap_pkg;
  localparam int STATE_W   = 320;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 10;

  localparam logic [4:0] ADDR_STATE_BASE  = 5'd0;
  localparam logic [4:0] ADDR_CTRL        = 5'd10;
  localparam logic [4:0] ADDR_STATUS      = 5'd11;
  localparam logic [4:0] ADDR_RESULT_BASE = 5'd12;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_START, S_POLL, S_POLL_WAIT, S_READ, S_READ_WAIT, S_DONE
  } state_t;

  // CSR word w holds half (w%2) of lane x_(w/2); lane x_k occupies
  // bits [319-64k -: 64], so the word's lsb is 256-64k (+32 for the high half).
  function automatic int word_lsb(input int w);
    return 256 - 64 * (w / 2) + 32 * (w % 2);
  endfunction
endpackage

// File: rtl/ap_bus_rd_port.sv
// Single-outstanding CSR read port.
//   clk, rst_n : clock, async active-low reset
//   issue      : request a read strobe in the next cycle
//   rd_n       : registered read strobe, active low
//   dvalid     : high in the cycle read data is valid (RD_LATENCY after strobe)
module ap_bus_rd_port #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic rd_n,
  output logic dvalid
);
  logic       pending;
  logic [1:0] cnt;   // cycles elapsed since the strobe cycle

  assign dvalid = pending && (cnt == 2'(RD_LATENCY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_n    <= 1'b1;
      pending <= 1'b0;
      cnt     <= '0;
    end else begin
      rd_n <= ~issue;
      if (issue) begin
        pending <= 1'b1;
        cnt     <= '0;
      end else if (pending) begin
        if (dvalid) pending <= 1'b0;
        else        cnt     <= cnt + 2'd1;
      end
    end
  end
endmodule

// File: rtl/ap_host_master.sv
// Bus initiator for the Ascon permutation CSR block.
// Takes a 320-bit state over valid/ready, writes it to CSR 0..9, pulses
// start (CSR 10), polls done (CSR 11), reads the result (CSR 12..21) and
// returns it over valid/ready. Poll timeout yields a one-cycle oError.
//   iState_valid/oState_ready/iState     : state input handshake
//   oResult_valid/iResult_ready/oResult  : result output handshake
//   oError                               : poll timeout pulse
//   oChip_select_n/oRead_n/oWrite_n/oAddress/oWriteData/iReadData : CSR bus
module ap_host_master
  import ap_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int POLL_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic         iClk,
  input  logic         iReset_n,
  input  logic         iState_valid,
  output logic         oState_ready,
  input  logic [319:0] iState,
  output logic         oResult_valid,
  input  logic         iResult_ready,
  output logic [319:0] oResult,
  output logic         oError,
  output logic         oChip_select_n,
  output logic         oRead_n,
  output logic         oWrite_n,
  output logic [4:0]   oAddress,
  output logic [31:0]  oWriteData,
  input  logic [31:0]  iReadData
);
  localparam logic [3:0]       LAST_WORD = 4'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(POLL_LIMIT);

  state_t             state;
  logic [STATE_W-1:0] st_q;
  logic [3:0]         word_cnt;
  logic [CNT_W-1:0]   poll_cnt;
  logic               rd_issue, rd_dvalid;

  // A read strobe is requested on exactly the edges that enter POLL or READ.
  always_comb begin
    rd_issue = 1'b0;
    case (state)
      S_START:     rd_issue = 1'b1;
      S_POLL_WAIT: rd_issue = rd_dvalid && (iReadData[0] || poll_cnt != LIMIT);
      S_READ_WAIT: rd_issue = rd_dvalid && (word_cnt != LAST_WORD);
      default:     rd_issue = 1'b0;
    endcase
  end

  ap_bus_rd_port #(.RD_LATENCY(RD_LATENCY)) u_rd (
    .clk(iClk), .rst_n(iReset_n), .issue(rd_issue), .rd_n(oRead_n), .dvalid(rd_dvalid)
  );

  // State names describe what the bus is doing in the current cycle; the
  // outputs for a state are registered on the edge that enters it.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state          <= S_IDLE;
      st_q           <= '0;
      word_cnt       <= '0;
      poll_cnt       <= '0;
      oState_ready   <= 1'b0;
      oResult_valid  <= 1'b0;
      oResult        <= '0;
      oError         <= 1'b0;
      oChip_select_n <= 1'b1;
      oWrite_n       <= 1'b1;
      oAddress       <= '0;
      oWriteData     <= '0;
    end else begin
      oError         <= 1'b0;
      oWrite_n       <= 1'b1;
      oChip_select_n <= ~rd_issue;
      case (state)
        S_IDLE: begin
          oState_ready <= 1'b1;
          if (iState_valid && oState_ready) begin
            st_q           <= iState;
            word_cnt       <= '0;
            oState_ready   <= 1'b0;
            oChip_select_n <= 1'b0;
            oWrite_n       <= 1'b0;
            oAddress       <= ADDR_STATE_BASE;
            oWriteData     <= iState[word_lsb(0) +: WORD_W];
            state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          oChip_select_n <= 1'b0;
          oWrite_n       <= 1'b0;
          if (word_cnt == LAST_WORD) begin
            oAddress   <= ADDR_CTRL;
            oWriteData <= 32'd1;
            state      <= S_START;
          end else begin
            word_cnt   <= word_cnt + 4'd1;
            oAddress   <= ADDR_STATE_BASE + 5'(word_cnt) + 5'd1;
            oWriteData <= st_q[word_lsb(int'(word_cnt) + 1) +: WORD_W];
          end
        end
        S_START: begin
          poll_cnt <= '0;
          oAddress <= ADDR_STATUS;
          state    <= S_POLL;
        end
        S_POLL: state <= S_POLL_WAIT;
        S_POLL_WAIT: begin
          if (rd_dvalid) begin
            if (iReadData[0]) begin
              word_cnt <= '0;
              oAddress <= ADDR_RESULT_BASE;
              state    <= S_READ;
            end else if (poll_cnt == LIMIT) begin
              oError       <= 1'b1;
              oState_ready <= 1'b1;
              state        <= S_IDLE;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
              oAddress <= ADDR_STATUS;
              state    <= S_POLL;
            end
          end
        end
        S_READ: state <= S_READ_WAIT;
        S_READ_WAIT: begin
          if (rd_dvalid) begin
            oResult[word_lsb(int'(word_cnt)) +: WORD_W] <= iReadData;
            if (word_cnt == LAST_WORD) begin
              oResult_valid <= 1'b1;
              state         <= S_DONE;
            end else begin
              word_cnt <= word_cnt + 4'd1;
              oAddress <= ADDR_RESULT_BASE + 5'(word_cnt) + 5'd1;
              state    <= S_READ;
            end
          end
        end
        S_DONE: begin
          if (iResult_ready) begin
            oResult_valid <= 1'b0;
            oState_ready  <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ap_host_master.sv
// Bench for ap_host_master: two instances (RD_LATENCY=1/POLL_LIMIT=255 and
// RD_LATENCY=3/POLL_LIMIT=3) each talking to a behavioural CSR slave whose
// "permutation" is a simple invertible mix, checked against a direct model.
module tb_ap_host_master;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         sv[2], srdy[2], rv[2], rr[2], err[2];
  logic [319:0] st[2], res[2];
  logic         cs_n[2], rd_n[2], wr_n[2];
  logic [4:0]   addr[2];
  logic [31:0]  wd[2], rdat[2];

  ap_host_master #(.RD_LATENCY(1), .POLL_LIMIT(255), .CNT_W(8)) dut0 (
    .iClk(clk), .iReset_n(rst_n), .iState_valid(sv[0]), .oState_ready(srdy[0]), .iState(st[0]),
    .oResult_valid(rv[0]), .iResult_ready(rr[0]), .oResult(res[0]), .oError(err[0]),
    .oChip_select_n(cs_n[0]), .oRead_n(rd_n[0]), .oWrite_n(wr_n[0]), .oAddress(addr[0]),
    .oWriteData(wd[0]), .iReadData(rdat[0]));

  ap_host_master #(.RD_LATENCY(3), .POLL_LIMIT(3), .CNT_W(2)) dut1 (
    .iClk(clk), .iReset_n(rst_n), .iState_valid(sv[1]), .oState_ready(srdy[1]), .iState(st[1]),
    .oResult_valid(rv[1]), .iResult_ready(rr[1]), .oResult(res[1]), .oError(err[1]),
    .oChip_select_n(cs_n[1]), .oRead_n(rd_n[1]), .oWrite_n(wr_n[1]), .oAddress(addr[1]),
    .oWriteData(wd[1]), .iReadData(rdat[1]));

  // ---------------- reference helpers ----------------
  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s);
    return {s[159:0], s[319:160]} ^ {5{64'h0F1E2D3C4B5A6978}};
  endfunction

  // CSR word w of a state: lane x_(w/2), low half for even w
  function automatic logic [31:0] get_word(input logic [319:0] s, input int w);
    logic [63:0] x;
    x = s[319 - 64 * (w / 2) -: 64];
    return (w % 2 == 1) ? x[63:32] : x[31:0];
  endfunction

  function automatic logic [319:0] pack(input logic [21:0][31:0] m);
    return {m[1], m[0], m[3], m[2], m[5], m[4], m[7], m[6], m[9], m[8]};
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // accept -> valid: 10 writes + start, then each read costs strobe + RD_LATENCY
  function automatic int exp_lat(input int i, input int polls);
    return 11 + (polls + 10) * (1 + lat(i));
  endfunction

  // ---------------- CSR slave model ----------------
  logic [21:0][31:0] mem[2];
  logic [31:0]       dl[2][3];
  logic [4:0]        wlog_a[2][512];
  logic [31:0]       wlog_d[2][512];
  int wcnt[2]    = '{0, 0};
  int sreads[2]  = '{0, 0};
  int rreads[2]  = '{0, 0};
  int polls[2]   = '{0, 0};
  int overlap[2] = '{0, 0};
  int buserr[2]  = '{0, 0};
  int last_rd[2] = '{-100, -100};
  int done_after[2];
  int cyc = 0;

  assign rdat[0] = dl[0][0];
  assign rdat[1] = dl[1][2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      dl[i][0] <= 32'hBAD0_0000;
      dl[i][1] <= dl[i][0];
      dl[i][2] <= dl[i][1];
      if (!cs_n[i] && !wr_n[i]) begin
        mem[i][addr[i]] <= wd[i];
        wlog_a[i][wcnt[i]] <= addr[i];
        wlog_d[i][wcnt[i]] <= wd[i];
        wcnt[i] <= wcnt[i] + 1;
        if (addr[i] == 5'd10 && wd[i][0]) begin
          polls[i] <= 0;
          for (int w = 0; w < 10; w++) mem[i][12 + w] <= get_word(perm(pack(mem[i])), w);
        end
      end
      if (!cs_n[i] && !rd_n[i]) begin
        if (cyc - last_rd[i] <= lat(i)) overlap[i] <= overlap[i] + 1;
        last_rd[i] <= cyc;
        if (addr[i] == 5'd11) begin
          sreads[i] <= sreads[i] + 1;
          polls[i]  <= polls[i] + 1;
          dl[i][0]  <= {31'd0, polls[i] >= done_after[i]};
        end else begin
          if (addr[i] >= 5'd12) rreads[i] <= rreads[i] + 1;
          dl[i][0] <= mem[i][addr[i]];
        end
      end
      if ((!rd_n[i] && !wr_n[i]) || (!cs_n[i] && rd_n[i] && wr_n[i]) || (cs_n[i] && (!rd_n[i] || !wr_n[i])))
        buserr[i] <= buserr[i] + 1;
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [319:0] s);
    int n = 0;
    while (!srdy[i] && n < 100) begin step(); n++; end
    chk("send_ready", srdy[i], 1'b1);
    sv[i] = 1'b1;
    st[i] = s;
    step();
    sv[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, output int n);
    n = 0;
    while (!rv[i] && n < 400) begin step(); n++; end
  endtask

  task automatic txn(input int i, input logic [319:0] s, input int da, input int hold);
    int n, bs, br, bw;
    logic [319:0] e;
    e = perm(s);
    done_after[i] = da;
    bs = sreads[i]; br = rreads[i]; bw = wcnt[i];
    send(i, s);
    wait_valid(i, n);
    chk("latency", n, exp_lat(i, da + 1));
    chk("result", res[i], e);
    chk("status_reads", sreads[i] - bs, da + 1);
    chk("result_reads", rreads[i] - br, 10);
    for (int j = 0; j < 11; j++)
      chk("write_log", {wlog_a[i][bw + j], wlog_d[i][bw + j]},
          {5'(j), (j < 10) ? get_word(s, j) : 32'd1});
    for (int h = 0; h < hold; h++) begin
      sv[i] = 1'b1;
      st[i] = rnd320();
      step();
      chk("bp_valid", rv[i], 1'b1);
      chk("bp_result", res[i], e);
      chk("bp_no_error", err[i], 1'b0);
    end
    sv[i] = 1'b0;
    rr[i] = 1'b1;
    step();
    rr[i] = 1'b0;
    chk("valid_drop", rv[i], 1'b0);
    chk("ready_back", srdy[i], 1'b1);
    chk("no_extra_accept", wcnt[i] - bw, 11);
  endtask

  initial begin
    int errcyc, sawv, bs, bw;
    logic [319:0] s;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; rr[i] = 1'b0; st[i] = '0; done_after[i] = 0;
    end
    #1 rst_n = 1'b0;
    #22;
    chk("rst_bus0", {cs_n[0], rd_n[0], wr_n[0], addr[0], wd[0]}, {3'b111, 5'd0, 32'd0});
    chk("rst_bus1", {cs_n[1], rd_n[1], wr_n[1], addr[1], wd[1]}, {3'b111, 5'd0, 32'd0});
    chk("rst_result", res[0], '0);
    chk("rst_flags", {srdy[0], rv[0], err[0], srdy[1], rv[1], err[1]}, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", {srdy[0], srdy[1]}, 2'b11);

    // basic vector, done on first poll
    txn(0, {64'h0123456789ABCDEF, 64'h0, 64'h0, 64'h0, 64'h80400C0600000000}, 0, 0);
    // slow done with result backpressure
    txn(0, rnd320(), 5, 7);

    // timeout on the POLL_LIMIT=3 instance
    done_after[1] = 1000;
    bs = sreads[1]; bw = wcnt[1];
    send(1, rnd320());
    errcyc = 0; sawv = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (err[1]) errcyc++;
      if (rv[1]) sawv++;
    end
    chk("timeout_err_pulse", errcyc, 1);
    chk("timeout_no_valid", sawv, 0);
    chk("timeout_status_reads", sreads[1] - bs, 4);
    chk("timeout_writes", wcnt[1] - bw, 11);
    chk("timeout_ready", srdy[1], 1'b1);

    // RD_LATENCY = 3 normal completion
    txn(1, rnd320(), 2, 0);

    // random traffic on both instances
    for (int r = 0; r < 3; r++) begin
      txn(0, rnd320(), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
      txn(1, rnd320(), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // reset while the 4th write is on the bus
    done_after[0] = 0;
    send(0, rnd320());
    begin
      int n = 0;
      while (!(!wr_n[0] && addr[0] == 5'd3) && n < 20) begin step(); n++; end
      chk("reached_4th_write", {wr_n[0], addr[0]}, {1'b0, 5'd3});
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bus", {cs_n[0], rd_n[0], wr_n[0], addr[0], wd[0]}, {3'b111, 5'd0, 32'd0});
    chk("midrst_flags", {srdy[0], rv[0], err[0], res[0] == '0}, 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("midrst_ready", srdy[0], 1'b1);
    s = rnd320();
    txn(0, s, 1, 0);

    chk("no_overlapping_reads", overlap[0] + overlap[1], 0);
    chk("bus_protocol", buserr[0] + buserr[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ap_host_master.md
Name: ap_host_master

Overview:
- Bus-initiator side of the Ascon permutation CSR interface.
- Accepts a 320-bit state (x0..x4) over a valid/ready handshake.
- Drives the CSR slave's chip-select/read/write/address/data bus to write the state, pulse start, poll done and read back the permuted state.
- Returns the result over a valid/ready handshake.
- Sits between a firmware-less datapath client (e.g. the AEAD sequencer) and the permutation CSR block.

Parameters:
- RD_LATENCY, 1, cycles from read strobe to valid iReadData (1..3).
- POLL_LIMIT, 255, maximum status reads before timeout error.
- CNT_W, 8, width of poll counter; must hold POLL_LIMIT.

Ports:
- iClk  in  1  clock
- iReset_n  in  1  asynchronous active-low reset
- iState_valid  in  1  input state offered
- oState_ready  out  1  block can accept a state (high only in IDLE)
- iState  in  320  {x0,x1,x2,x3,x4}, x0 in [319:256]
- oResult_valid  out  1  permuted state available
- iResult_ready  in  1  consumer accepts result
- oResult  out  320  permuted {x0..x4}, same packing
- oError  out  1  one-cycle pulse on poll timeout
- oChip_select_n  out  1  bus select, active low
- oRead_n  out  1  read strobe, active low
- oWrite_n  out  1  write strobe, active low
- oAddress  out  5  CSR word address
- oWriteData  out  32  write data
- iReadData  in  32  read data from CSR

Behaviour:
- CSR map (fixed):
  - 0..9: state in. Address 2k = x_k[31:0], 2k+1 = x_k[63:32].
  - 10: control, bit0 = start (self-clearing in slave).
  - 11: status, bit0 = done.
  - 12..21: result, same word order.
- Reset (async):
  - oChip_select_n = oRead_n = oWrite_n = 1.
  - oAddress = 0, oWriteData = 0, oResult = 0.
  - oState_ready = 0 during reset, 1 in the first cycle after release.
  - oResult_valid = 0, oError = 0.
  - FSM goes to IDLE.
- Bus rules:
  - At most one access per cycle; read and write never asserted together.
  - Chip select is asserted only together with a strobe.
  - All bus outputs are registered.
- FSM states:
  - IDLE: oState_ready = 1. On iState_valid & oState_ready, latch iState, clear word counter, go to WRITE.
  - WRITE: one write per cycle to addresses 0..9 with the corresponding word. After address 9, go to START.
  - START: single write, address 10, data 0x00000001. Clear poll counter, go to POLL.
  - POLL: issue read to address 11, go to POLL_WAIT.
  - POLL_WAIT: strobes deasserted. Wait RD_LATENCY cycles, then sample iReadData[0].
    - If 1: go to READ.
    - Else if poll count = POLL_LIMIT: pulse oError, go to IDLE; no result is produced.
    - Else: increment count, go to POLL.
  - READ: issue read to address 12+n, wait RD_LATENCY, capture the word into the result register. Reads are not pipelined: exactly one outstanding read. After n = 9, go to DONE.
  - DONE: oResult_valid = 1, oResult stable. On iResult_ready, drop valid and go to IDLE.
    - Valid and ready in the same cycle completes the transfer.
    - iResult_ready without valid is ignored.
- Latency (RD_LATENCY = 1, done on first poll): accept to oResult_valid = 10 writes + 1 start + 2 poll + 20 read = 33 cycles.
- Boundaries:
  - iState_valid while busy is ignored (ready low); no command queue.
  - Poll counter saturates at POLL_LIMIT, never wraps.
  - Reset mid-transaction: strobes deassert asynchronously; a partially written state is abandoned, and the slave is expected to be re-armed by a fresh command.
  - oError and oResult_valid are never high in the same cycle.

Decomposition:
- Shared package ap_pkg:
  - CSR address constants (ADDR_STATE_BASE = 0, ADDR_CTRL = 10, ADDR_STATUS = 11, ADDR_RESULT_BASE = 12).
  - STATE_W = 320, WORD_W = 32, NUM_WORDS = 10.
  - FSM state enum.
- One natural sub-module, ap_bus_rd_port: issues a single read, counts RD_LATENCY, returns a data-valid pulse. It is reused by POLL and READ.

Test Plan:
- Basic: iState = x0..x4 = 0x0123456789ABCDEF, 0, 0, 0, 0x80400C0600000000 against the real CSR+core pair.
  - Bus log shows writes 0..9 (addr0 = 0x89ABCDEF, addr1 = 0x01234567), then write addr10 = 1.
  - oResult equals the 6-round reference model output.
- Slow done: slave model returns done = 0 for 5 polls → exactly 6 status reads, then 10 result reads. Result word k read from address 12+k lands in the correct slice.
- Timeout: done never set, POLL_LIMIT = 3 → 4 status reads, then a one-cycle oError pulse. oResult_valid stays 0 and the block returns to IDLE with oState_ready = 1.
- Backpressure: iResult_ready held low 7 cycles → oResult_valid and oResult stable throughout. iState_valid pulses during this time are not accepted.
- RD_LATENCY = 3: slave model delays data by 3 cycles → no overlapping reads, correct capture.
- Reset at the 4th write: strobes go high asynchronously, all outputs return to reset values. A new command completes normally with correct result.
